// File: rtl/axis_tdest_rr_scheduler_if.sv
// Stream bundle between the per-channel AXI-Stream sources, the round-robin scheduler and the DMA side.
// The master modport is the environment around the scheduler, and the slave modport is the scheduler itself.
interface axis_tdest_rr_scheduler_if #(
  parameter int AXIS_BYTES  = 4,
  parameter int NUM_STREAMS = 8,
  parameter int DEST_WIDTH  = 4
);
  logic [NUM_STREAMS*AXIS_BYTES*8-1:0] axis_i_tdata;
  logic [NUM_STREAMS*DEST_WIDTH-1:0]   axis_i_tdest;
  logic [NUM_STREAMS-1:0]              axis_i_tvalid;
  logic [NUM_STREAMS-1:0]              axis_i_tready;
  logic [AXIS_BYTES*8-1:0]             axis_o_tdata;
  logic [DEST_WIDTH-1:0]               axis_o_tdest;
  logic                                axis_o_tlast;
  logic                                axis_o_tvalid;
  logic                                axis_o_tready;

  modport master (
    output axis_i_tdata, axis_i_tdest, axis_i_tvalid,
    input  axis_i_tready,
    input  axis_o_tdata, axis_o_tdest, axis_o_tlast, axis_o_tvalid,
    output axis_o_tready
  );

  modport slave (
    input  axis_i_tdata, axis_i_tdest, axis_i_tvalid,
    output axis_i_tready,
    output axis_o_tdata, axis_o_tdest, axis_o_tlast, axis_o_tvalid,
    input  axis_o_tready
  );
endinterface

// File: rtl/axis_tdest_rr_scheduler.sv
// Round-robin merge of NUM_STREAMS tdest streams into one registered AXI-Stream output.
// The merged stream is framed into packets of words_to_send words.
//   state | meaning
//   IDLE  | waiting for enable with a non-zero length; output idle
//   RUN   | granting words until len are loaded and the tlast beat is accepted
module axis_tdest_rr_scheduler #(
  parameter int AXIS_BYTES  = 4,
  parameter int NUM_STREAMS = 8,
  parameter int DEST_WIDTH  = 4
) (
  input  logic                   clk,
  input  logic                   sreset,
  input  logic                   enable,
  input  logic [31:0]            words_to_send,
  input  logic [NUM_STREAMS-1:0] chan_mask,
  axis_tdest_rr_scheduler_if.slave bus,
  output logic                   busy,
  output logic [31:0]            words_sent
);
  localparam int DW = AXIS_BYTES * 8;
  localparam int PW = $clog2(NUM_STREAMS);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state;
  logic [31:0]           len;
  logic [PW-1:0]         ptr;
  logic [DW-1:0]         o_tdata;
  logic [DEST_WIDTH-1:0] o_tdest;
  logic                  o_tlast;
  logic                  o_tvalid;

  logic                   out_free;
  logic [NUM_STREAMS-1:0] cand;
  logic [NUM_STREAMS-1:0] gnt_onehot;
  logic                   gnt_any;
  logic [PW-1:0]          gnt_idx;
  logic [PW-1:0]          idx_b;
  int                     idx;

  assign bus.axis_o_tdata  = o_tdata;
  assign bus.axis_o_tdest  = o_tdest;
  assign bus.axis_o_tlast  = o_tlast;
  assign bus.axis_o_tvalid = o_tvalid;
  assign bus.axis_i_tready = gnt_onehot;

  // Search starts one past the last granted channel, so every channel gets one word per round.
  always_comb begin
    gnt_any    = 1'b0;
    gnt_idx    = '0;
    gnt_onehot = '0;
    idx        = 0;
    idx_b      = '0;
    out_free   = !o_tvalid || bus.axis_o_tready;
    cand       = bus.axis_i_tvalid & chan_mask;
    if (state == RUN && out_free && words_sent < len) begin
      for (int i = 1; i <= NUM_STREAMS; i++) begin
        idx = int'(ptr) + i;
        if (idx >= NUM_STREAMS) idx = idx - NUM_STREAMS;
        idx_b = PW'(idx);
        if (!gnt_any && cand[idx_b]) begin
          gnt_any = 1'b1;
          gnt_idx = idx_b;
        end
      end
    end
    if (gnt_any) gnt_onehot[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      state      <= IDLE;
      len        <= '0;
      words_sent <= '0;
      ptr        <= PW'(NUM_STREAMS - 1);
      o_tdata    <= '0;
      o_tdest    <= '0;
      o_tlast    <= 1'b0;
      o_tvalid   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_tvalid <= 1'b0;
          o_tlast  <= 1'b0;
          if (enable && words_to_send != 32'd0) begin
            len        <= words_to_send;
            words_sent <= '0;
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (gnt_any) begin
            o_tdata    <= bus.axis_i_tdata[gnt_idx*DW +: DW];
            o_tdest    <= bus.axis_i_tdest[gnt_idx*DEST_WIDTH +: DEST_WIDTH];
            o_tlast    <= (words_sent == len - 32'd1);
            o_tvalid   <= 1'b1;
            words_sent <= words_sent + 32'd1;
            ptr        <= gnt_idx;
          end else if (out_free) begin
            o_tvalid <= 1'b0;
            o_tlast  <= 1'b0;
          end
          // No grant can coincide with the tlast handshake because words_sent == len by then.
          if (o_tvalid && bus.axis_o_tready && o_tlast) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axis_tdest_rr_scheduler.sv
// Bench for axis_tdest_rr_scheduler: a packet-level reference model is compared on every cycle.
// Directed scenarios also check hand-computed beat sequences.
module tb_axis_tdest_rr_scheduler;
  localparam int NS  = 8;
  localparam int AB  = 4;
  localparam int DDW = 4;
  localparam int DW  = AB * 8;

  logic          clk = 1'b0;
  logic          sreset;
  logic          enable;
  logic [31:0]   wts;
  logic [NS-1:0] chan_mask;
  logic          busy;
  logic [31:0]   words_sent;

  axis_tdest_rr_scheduler_if #(.AXIS_BYTES(AB), .NUM_STREAMS(NS), .DEST_WIDTH(DDW)) bus ();

  axis_tdest_rr_scheduler #(.AXIS_BYTES(AB), .NUM_STREAMS(NS), .DEST_WIDTH(DDW)) dut (
    .clk(clk), .sreset(sreset), .enable(enable), .words_to_send(wts),
    .chan_mask(chan_mask), .bus(bus), .busy(busy), .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: packet bookkeeping plus the last channel served.
  bit          m_ok = 1'b0;
  bit          m_busy, m_ov, m_olast;
  int unsigned m_len, m_sent;
  int          m_last;
  logic [31:0] m_od;
  logic [3:0]  m_odest;

  function automatic int exp_grant();
    int c;
    if (!m_busy) return -1;
    if (m_ov && !bus.axis_o_tready) return -1;
    if (m_sent >= m_len) return -1;
    for (int s = 1; s <= NS; s++) begin
      c = (m_last + s) % NS;
      if (bus.axis_i_tvalid[c] && chan_mask[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int g;
    bit hs_last;
    if (sreset) begin
      m_ok = 1'b1; m_busy = 1'b0; m_ov = 1'b0; m_olast = 1'b0;
      m_od = '0; m_odest = '0; m_len = 0; m_sent = 0; m_last = NS - 1;
    end else if (m_ok) begin
      if (!m_busy) begin
        if (enable && wts != 0) begin
          m_busy = 1'b1; m_len = wts; m_sent = 0;
        end
      end else begin
        g = exp_grant();
        hs_last = m_ov && bus.axis_o_tready && m_olast;
        if (g >= 0) begin
          m_od    = bus.axis_i_tdata[g*DW +: DW];
          m_odest = bus.axis_i_tdest[g*DDW +: DDW];
          m_olast = (m_sent + 1 == m_len);
          m_ov    = 1'b1;
          m_sent++;
          m_last  = g;
        end else if (!m_ov || bus.axis_o_tready) begin
          m_ov = 1'b0; m_olast = 1'b0;
        end
        if (hs_last) m_busy = 1'b0;
      end
    end
  end

  int busy_cycles = 0;

  always @(negedge clk) begin : compare
    int g;
    logic [NS-1:0] et;
    if (m_ok) begin
      g  = exp_grant();
      et = (g >= 0) ? (NS'(1) << g) : '0;
      chk("tvalid", 64'(bus.axis_o_tvalid), 64'(m_ov));
      chk("tlast", 64'(bus.axis_o_tlast), 64'(m_olast));
      if (m_ov) begin
        chk("tdata", 64'(bus.axis_o_tdata), 64'(m_od));
        chk("tdest", 64'(bus.axis_o_tdest), 64'(m_odest));
      end
      chk("busy", 64'(busy), 64'(m_busy));
      chk("words_sent", 64'(words_sent), 64'(m_sent));
      chk("i_tready", 64'(bus.axis_i_tready), 64'(et));
      if (busy) busy_cycles++;
    end
  end

  logic [31:0] bq_data[$];
  logic [3:0]  bq_dest[$];
  logic        bq_last[$];
  int          tready_pulses = 0;
  logic [NS-1:0] tready_seen = '0;

  always @(posedge clk) begin : collect
    if (m_ok && !sreset) begin
      if (bus.axis_o_tvalid && bus.axis_o_tready) begin
        bq_data.push_back(bus.axis_o_tdata);
        bq_dest.push_back(bus.axis_o_tdest);
        bq_last.push_back(bus.axis_o_tlast);
      end
      tready_pulses += $countones(bus.axis_i_tready);
      tready_seen   |= bus.axis_i_tready;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    bq_data.delete(); bq_dest.delete(); bq_last.delete();
    tready_pulses = 0; tready_seen = '0; busy_cycles = 0;
  endtask

  task automatic start_pkt(input logic [31:0] len);
    enable = 1'b1;
    wts    = len;
    step(1);
    enable = 1'b0;
  endtask

  task automatic run_packet(input int budget, input bit toggle);
    int c;
    c = 0;
    while (busy && c < budget) begin
      if (toggle) bus.axis_o_tready = ~bus.axis_o_tready;
      step(1);
      c++;
    end
    chk("packet_done", 64'(busy), 64'(0));
  endtask

  task automatic chk_seq(input string name, input int exp_ch[$]);
    chk({name, "_count"}, 64'(bq_data.size()), 64'(exp_ch.size()));
    for (int i = 0; i < bq_data.size() && i < exp_ch.size(); i++) begin
      chk({name, "_data"}, 64'(bq_data[i]), 64'(exp_ch[i]));
      chk({name, "_dest"}, 64'(bq_dest[i]), 64'(exp_ch[i] + 1));
      chk({name, "_last"}, 64'(bq_last[i]), 64'(i == exp_ch.size() - 1));
    end
  endtask

  initial begin
    int seq[$];
    sreset = 1'b1; enable = 1'b0; wts = '0; chan_mask = '1;
    bus.axis_i_tvalid = '0; bus.axis_o_tready = 1'b1;
    for (int k = 0; k < NS; k++) begin
      bus.axis_i_tdata[k*DW +: DW]  = 32'(k);
      bus.axis_i_tdest[k*DDW +: DDW] = 4'(k + 1);
    end
    step(2);
    sreset = 1'b0;
    chk("rst_tvalid", 64'(bus.axis_o_tvalid), 64'(0));
    chk("rst_tdata", 64'(bus.axis_o_tdata), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_words", 64'(words_sent), 64'(0));
    chk("rst_tready", 64'(bus.axis_i_tready), 64'(0));

    // 1: full-rate, all channels valid
    clr(); bus.axis_i_tvalid = '1; chan_mask = 8'hFF; bus.axis_o_tready = 1'b1;
    start_pkt(16);
    run_packet(100, 1'b0);
    seq.delete();
    for (int i = 0; i < 16; i++) seq.push_back(i % 8);
    chk_seq("s1", seq);
    chk("s1_busy_cycles", 64'(busy_cycles), 64'(17));
    chk("s1_words_sent", 64'(words_sent), 64'(16));

    // 2: downstream ready toggling
    clr(); bus.axis_o_tready = 1'b1;
    start_pkt(16);
    run_packet(200, 1'b1);
    chk_seq("s2", seq);
    chk("s2_tready_pulses", 64'(tready_pulses), 64'(16));
    bus.axis_o_tready = 1'b1;
    step(2);

    // 3: sparse mask
    clr(); chan_mask = 8'h05; bus.axis_i_tvalid = 8'h05;
    start_pkt(5);
    run_packet(50, 1'b0);
    seq = '{0, 2, 0, 2, 0};
    chk_seq("s3", seq);
    chk("s3_masked_tready", 64'(tready_seen & 8'hFA), 64'(0));

    // 4: enable pulse, length changed mid-packet
    clr(); chan_mask = 8'hFF; bus.axis_i_tvalid = 8'hFF;
    start_pkt(4);
    wts = 100;
    run_packet(50, 1'b0);
    step(8);
    seq = '{1, 2, 3, 4};
    chk_seq("s4", seq);
    chk("s4_busy", 64'(busy), 64'(0));
    chk("s4_words_sent", 64'(words_sent), 64'(4));

    // 5: zero length stays idle, then a one-word packet
    clr(); enable = 1'b1; wts = 0;
    step(5);
    chk("s5_busy", 64'(busy), 64'(0));
    chk("s5_tready", 64'(tready_seen), 64'(0));
    chk("s5_beats", 64'(bq_data.size()), 64'(0));
    start_pkt(1);
    run_packet(20, 1'b0);
    seq = '{5};
    chk_seq("s5", seq);

    // 6: reset while stalled
    clr(); bus.axis_o_tready = 1'b0;
    start_pkt(16);
    step(3);
    chk("s6_stalled_valid", 64'(bus.axis_o_tvalid), 64'(1));
    chk("s6_stalled_data", 64'(bus.axis_o_tdata), 64'(6));
    chk("s6_no_beats", 64'(bq_data.size()), 64'(0));
    sreset = 1'b1;
    step(1);
    chk("s6_rst_tvalid", 64'(bus.axis_o_tvalid), 64'(0));
    chk("s6_rst_busy", 64'(busy), 64'(0));
    chk("s6_rst_words", 64'(words_sent), 64'(0));
    sreset = 1'b0; bus.axis_o_tready = 1'b1;
    clr();
    start_pkt(2);
    run_packet(20, 1'b0);
    seq = '{0, 1};
    chk_seq("s6", seq);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_tdest_rr_scheduler.md
Name: axis_tdest_rr_scheduler

Overview:
- Round-robin scheduler that shares one AXI-Stream output between NUM_STREAMS per-channel tdest streams (the ADC channel-pair word streams) and frames the result into packets of words_to_send words.
- Sits between the per-channel vector-to-axis stages and the DMA-facing stream.
- Driven by EnableSampleGeneration and PacketSize from the AXI-Lite register block.

Parameters:
- AXIS_BYTES, 4, bytes per tdata word.
- NUM_STREAMS, 8, number of input streams; must be 2..16.
- DEST_WIDTH, 4, tdest width on inputs and output.

Ports:
- clk  input  1  single clock for all logic.
- sreset  input  1  synchronous reset, active-high.
- enable  input  1  level; starts a packet when high in IDLE.
- words_to_send  input  32  packet length in words; sampled at packet start.
- chan_mask  input  NUM_STREAMS  1 = channel eligible for grant; sampled every cycle.
- axis_i_tdata  input  NUM_STREAMS*AXIS_BYTES*8  channel k occupies slice k.
- axis_i_tdest  input  NUM_STREAMS*DEST_WIDTH  channel k occupies slice k.
- axis_i_tvalid  input  NUM_STREAMS  per-channel valid.
- axis_i_tready  output  NUM_STREAMS  one-hot or zero; grant/accept.
- axis_o_tdata  output  AXIS_BYTES*8  registered.
- axis_o_tdest  output  DEST_WIDTH  registered; copied from granted channel.
- axis_o_tlast  output  1  registered; high on the final word of a packet.
- axis_o_tvalid  output  1  registered.
- axis_o_tready  input  1  downstream ready.
- busy  output  1  high in RUN.
- words_sent  output  32  words loaded in the current or last packet.

Behaviour:
- Reset (sreset=1 at a clk edge) forces:
  - state=IDLE; all axis_o_* = 0; axis_i_tready = 0; busy = 0; words_sent = 0.
  - Round-robin pointer = NUM_STREAMS-1, so channel 0 has first priority.
- Reset mid-packet drops the output word in flight; no partial tlast is emitted.
- States: IDLE and RUN.
- IDLE:
  - If enable=1 and words_to_send!=0: latch len=words_to_send, clear words_sent, go to RUN the next cycle.
  - words_to_send=0 keeps the block in IDLE.
- Output register state:
  - out_free = !axis_o_tvalid || axis_o_tready.
- RUN, grant logic:
  - Grant is combinational.
  - cand = axis_i_tvalid & chan_mask.
  - If out_free and words_sent < len and cand != 0, grant the first set bit of cand searching from ptr+1 upward, with wrap-around.
  - axis_i_tready is asserted only for the granted bit; all other bits are 0.
- RUN, on a grant:
  - Next edge loads axis_o_tdata/tdest from the granted slice and sets axis_o_tvalid=1.
  - axis_o_tlast = (words_sent == len-1).
  - words_sent increments; ptr <= granted index.
- RUN, output hold:
  - If out_free and nothing is granted, axis_o_tvalid drops to 0 (and tlast to 0).
  - If the output is stalled, tdata/tdest/tlast/tvalid hold stable until tready.
- Leaving RUN:
  - The beat with tvalid & tready & tlast returns to IDLE on the next edge; busy falls there.
  - words_sent holds its final value until the next packet start.
- Throughput and latency:
  - One word per cycle while tready=1 and an eligible channel is valid.
  - Input accept to axis_o_tvalid is 1 cycle.
  - No bubbles between back-to-back grants.
- enable deasserted mid-packet: the packet completes to len words; there is no truncation. After that the block enters IDLE and starts nothing new.
- enable held high: a new packet starts 1 cycle after the last-beat handshake, because IDLE re-samples enable.
- chan_mask=0 or no valid inputs in RUN: the block waits indefinitely with no grant and keeps its state.
- Changing chan_mask mid-packet takes effect on the next grant decision.
- A masked channel never sees tready.
- Simultaneous valid on all channels: service order is ptr+1, ptr+2, ... (wrap). Fairness is one word per channel per round.
- len=1: the first and only word carries tlast.
- words_to_send changing mid-packet has no effect, because len is latched.

Test Plan:
1. Reset, then enable=1, words_to_send=16, mask=0xFF, all 8 inputs always valid with tdata=k, tdest=k+1, tready=1:
   - Output order is channel 0,1,...,7,0,...,7, with tdest 1..8 repeating.
   - tlast only on word 16; busy high for 17 cycles; words_sent=16.
2. As scenario 1 but tready toggles 1,0 each cycle:
   - Output data is held stable during stalls; no word is lost or duplicated.
   - Exactly 16 beats; the input tready pulse count equals 16.
3. mask=0x05, only channels 0 and 2 valid, words_to_send=5:
   - Output sequence is ch0,ch2,ch0,ch2,ch0, with tlast on the 5th beat.
   - Channels 1 and 3..7 never see tready.
4. enable=1 for one cycle, words_to_send=4, then enable=0; also set words_to_send=100 mid-packet:
   - Exactly 4 words; the block returns to IDLE and stays there.
   - words_sent=4.
5. words_to_send=0 with enable=1:
   - The block stays in IDLE with busy=0 and no tready asserted.
   - Then words_to_send=1 gives a single beat with tlast=1.
6. Assert sreset in the middle of a packet while the output is stalled (tready=0):
   - The next cycle shows tvalid=0, busy=0, words_sent=0.
   - After release the first grant goes to channel 0.
